// File: rtl/alu_control_stage.sv
// -----------------------------------------------------------------------------
// alu_control_stage
//
// Purpose:
//   This is a registered pipeline stage between ID/EX and the ALU. It decodes a
//   32-bit MIPS instruction into an ALUOp code and holds the result behind a
//   valid/ready handshake. A multiply-class op (mult, multu, mul, madd, msub)
//   keeps the ALU busy for MUL_CYCLES cycles. A small two-state FSM refuses new
//   instructions until the multiply has finished.
//
// Parameters:
//   OP_W        ALUOp width (>= 5). The 5-bit codes are zero-extended to OP_W.
//   MUL_CYCLES  Cycles a multiply-class op occupies the ALU (>= 1).
//
// Optional build macro:
//   ALU_CTRL_STATS_EN  When defined, the module adds the AcceptCount and
//                      MulStallCount outputs and their 32-bit wrapping counters.
//
// Ports:
//   Clk           in   clock, rising edge
//   Rst           in   synchronous active-high reset
//   Instruction   in   [31:0] instruction to decode
//   InValid       in   Instruction is valid this cycle
//   InReady       out  stage can accept an instruction (combinational)
//   Stall         in   downstream cannot take the output this cycle
//   Flush         in   kill the held output and any multiply in progress
//   OutValid      out  registered output is valid
//   ALUOp         out  [OP_W-1:0] registered ALU operation code
//   IsMulClass    out  registered: the held op is multiply-class
//   Illegal       out  registered: the held instruction did not decode
//   MulBusy       out  FSM is waiting out a multiply
//   AcceptCount   out  [31:0] accepted instructions (stats build only)
//   MulStallCount out  [31:0] cycles with MulBusy && InValid (stats build only)
// -----------------------------------------------------------------------------
module alu_control_stage #(
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [31:0]     Instruction,
    input  logic            InValid,
    output logic            InReady,
    input  logic            Stall,
    input  logic            Flush,
    output logic            OutValid,
    output logic [OP_W-1:0] ALUOp,
    output logic            IsMulClass,
    output logic            Illegal,
    output logic            MulBusy
`ifdef ALU_CTRL_STATS_EN
    ,
    output logic [31:0]     AcceptCount,
    output logic [31:0]     MulStallCount
`endif
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] code;
        logic       mul;
        logic       ill;
    } dec_t;

    // Decode table. Any encoding not listed here yields code 0 with ill set.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.code = 5'b00000;
        d.mul  = 1'b0;
        d.ill  = 1'b0;
        case (ins[31:26])
            6'b000000: begin
                case (ins[5:0])
                    6'b100000: d.code = 5'b00000; // add
                    6'b100001: d.code = 5'b01100; // addu
                    6'b100100: d.code = 5'b00011; // and
                    6'b100111: d.code = 5'b00110; // nor
                    6'b100101: d.code = 5'b00100; // or
                    6'b100010: d.code = 5'b00001; // sub
                    6'b100110: d.code = 5'b00101; // xor
                    6'b000000: d.code = 5'b00111; // sll
                    6'b000100: d.code = 5'b10001; // sllv
                    6'b000011: d.code = 5'b01010; // sra
                    6'b000111: d.code = 5'b10011; // srav
                    // srl/rotr share a funct; bit 21 (the R field) selects rotate
                    6'b000010: d.code = ins[21] ? 5'b01001 : 5'b01000;
                    // srlv/rotrv share a funct; bit 6 selects rotate
                    6'b000110: d.code = ins[6] ? 5'b10100 : 5'b10010;
                    6'b101010: d.code = 5'b01110; // slt
                    6'b101011: d.code = 5'b10000; // sltu
                    6'b001011,
                    6'b001010: d.code = 5'b10101; // movn / movz
                    6'b011000: begin d.code = 5'b00010; d.mul = 1'b1; end // mult
                    6'b011001: begin d.code = 5'b01101; d.mul = 1'b1; end // multu
                    default:   d.ill = 1'b1;
                endcase
            end
            6'b001000: d.code = 5'b00000; // addi
            6'b001001: d.code = 5'b01100; // addiu
            6'b001010: d.code = 5'b01110; // slti
            6'b001011: d.code = 5'b10000; // sltiu
            6'b001100: d.code = 5'b00011; // andi
            6'b001101: d.code = 5'b00100; // ori
            6'b001110: d.code = 5'b00101; // xori
            6'b011100: begin
                // SPECIAL2: mul, madd and msub all map onto the multiplier
                if (ins[5:0] == 6'b000010 || ins[5:0] == 6'b000000 ||
                    ins[5:0] == 6'b000100) begin
                    d.code = 5'b00010;
                    d.mul  = 1'b1;
                end else begin
                    d.ill = 1'b1;
                end
            end
            6'b011111: begin
                // SPECIAL3 BSHFL: the sa field picks seb or seh
                if (ins[5:0] == 6'b100000 && ins[10:6] == 5'b10000) begin
                    d.code = 5'b01111;
                end else if (ins[5:0] == 6'b100000 && ins[10:6] == 5'b11000) begin
                    d.code = 5'b01011;
                end else begin
                    d.ill = 1'b1;
                end
            end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             is_mul_q, is_mul_d;
    logic             illegal_q, illegal_d;
    dec_t             dec;
    logic             accept;
    logic             unused_ins_bits;

    // The decoder does not look at the register fields, apart from bit 21.
    assign unused_ins_bits = ^{Instruction[25:22], Instruction[20:11]};

    assign dec     = decode(Instruction);
    assign InReady = !Flush && (state_q == IDLE) && !(out_valid_q && Stall);
    assign accept  = InValid && InReady;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        is_mul_d    = is_mul_q;
        illegal_d   = illegal_q;

        // Output register: load on accept, hold under stall, otherwise drain.
        // When the stage drains, only the valid bit drops. The payload keeps its last value.
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_op_d    = OP_W'(dec.code);
            is_mul_d    = dec.mul;
            illegal_d   = dec.ill;
        end else if (!(out_valid_q && Stall)) begin
            out_valid_d = 1'b0;
        end

        // Multiply sequencer. The counter ignores Stall because the ALU is busy
        // either way.
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MUL_CYCLES > 1 && accept && dec.mul) begin
                        state_d = MULWAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                MULWAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stage boundary: decoded instruction -> ALU
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            is_mul_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            is_mul_q    <= is_mul_d;
            illegal_q   <= illegal_d;
        end
    end

    assign OutValid   = out_valid_q;
    assign ALUOp      = alu_op_q;
    assign IsMulClass = is_mul_q;
    assign Illegal    = illegal_q;
    assign MulBusy    = (state_q == MULWAIT);

`ifdef ALU_CTRL_STATS_EN
    logic [31:0] accept_cnt_q;
    logic [31:0] mul_stall_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            accept_cnt_q    <= '0;
            mul_stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                accept_cnt_q <= accept_cnt_q + 32'd1;
            end
            if (MulBusy && InValid) begin
                mul_stall_cnt_q <= mul_stall_cnt_q + 32'd1;
            end
        end
    end

    assign AcceptCount   = accept_cnt_q;
    assign MulStallCount = mul_stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_control_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_control_stage
//
// Purpose:
//   Directed bench for alu_control_stage with OP_W=5 and MUL_CYCLES=4. Every
//   expected value below was worked out by hand from the decode table and the
//   handshake rules. Inputs change 1 time unit after the rising edge. Outputs
//   are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_alu_control_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Instruction;
    logic        InValid;
    logic        InReady;
    logic        Stall;
    logic        Flush;
    logic        OutValid;
    logic [4:0]  ALUOp;
    logic        IsMulClass;
    logic        Illegal;
    logic        MulBusy;
`ifdef ALU_CTRL_STATS_EN
    logic [31:0] AcceptCount;
    logic [31:0] MulStallCount;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 Clk = ~Clk;

    alu_control_stage #(.OP_W(5), .MUL_CYCLES(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Instruction(Instruction),
        .InValid    (InValid),
        .InReady    (InReady),
        .Stall      (Stall),
        .Flush      (Flush),
        .OutValid   (OutValid),
        .ALUOp      (ALUOp),
        .IsMulClass (IsMulClass),
        .Illegal    (Illegal),
        .MulBusy    (MulBusy)
`ifdef ALU_CTRL_STATS_EN
        ,
        .AcceptCount  (AcceptCount),
        .MulStallCount(MulStallCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] sa);
        return {6'b000000, rs, 5'd2, 5'd3, sa, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h0005};
    endfunction

    logic [31:0] tv_ins [8];
    logic [4:0]  tv_op  [8];

    initial begin
        Rst         = 1'b1;
        Instruction = 32'h0;
        InValid     = 1'b0;
        Stall       = 1'b0;
        Flush       = 1'b0;
        step();
        step();
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_aluop", {27'b0, ALUOp}, 32'd0);
        chk("rst_ismul", {31'b0, IsMulClass}, 32'd0);
        chk("rst_illegal", {31'b0, Illegal}, 32'd0);
        chk("rst_mulbusy", {31'b0, MulBusy}, 32'd0);
        Rst = 1'b0;

        // add: result appears one cycle after acceptance
        Instruction = r_ins(6'b100000, 5'd1, 5'd0);
        InValid     = 1'b1;
        #1;
        chk("add_inready", {31'b0, InReady}, 32'd1);
        step();
        chk("add_outvalid", {31'b0, OutValid}, 32'd1);
        chk("add_aluop", {27'b0, ALUOp}, 32'h00);
        chk("add_illegal", {31'b0, Illegal}, 32'd0);
        chk("add_ismul", {31'b0, IsMulClass}, 32'd0);

        // shift/rotate selector bits
        Instruction = r_ins(6'b000010, 5'd0, 5'd4);   // srl, bit21=0
        step();
        chk("srl_aluop", {27'b0, ALUOp}, 32'h08);
        Instruction = r_ins(6'b000110, 5'd2, 5'd1);   // rotrv, bit6=1
        step();
        chk("rotrv_aluop", {27'b0, ALUOp}, 32'h14);
        Instruction = r_ins(6'b000010, 5'd1, 5'd4);   // rotr, bit21=1
        step();
        chk("rotr_aluop", {27'b0, ALUOp}, 32'h09);

        // mult, then addi held valid across the 3 MULWAIT cycles
        Instruction = r_ins(6'b011000, 5'd1, 5'd0);
        step();
        chk("mult_outvalid", {31'b0, OutValid}, 32'd1);
        chk("mult_aluop", {27'b0, ALUOp}, 32'h02);
        chk("mult_ismul", {31'b0, IsMulClass}, 32'd1);
        Instruction = i_ins(6'b001000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mulwait%0d_busy", i), {31'b0, MulBusy}, 32'd1);
            chk($sformatf("mulwait%0d_inready", i), {31'b0, InReady}, 32'd0);
            step();
            if (i == 0) chk("mulwait_outvalid_drop", {31'b0, OutValid}, 32'd0);
        end
        chk("mulwait_done_busy", {31'b0, MulBusy}, 32'd0);
        chk("mulwait_done_inready", {31'b0, InReady}, 32'd1);
        step();
        chk("addi_outvalid", {31'b0, OutValid}, 32'd1);
        chk("addi_aluop", {27'b0, ALUOp}, 32'h00);
        chk("addi_ismul", {31'b0, IsMulClass}, 32'd0);

        // ori, then 3 stalled cycles
        Instruction = i_ins(6'b001101);
        step();
        chk("ori_aluop", {27'b0, ALUOp}, 32'h04);
        Instruction = i_ins(6'b001110);               // xori waits behind the stall
        Stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_inready", i), {31'b0, InReady}, 32'd0);
            step();
            chk($sformatf("stall%0d_outvalid", i), {31'b0, OutValid}, 32'd1);
            chk($sformatf("stall%0d_aluop", i), {27'b0, ALUOp}, 32'h04);
        end
        Stall = 1'b0;
        #1;
        chk("unstall_inready", {31'b0, InReady}, 32'd1);
        step();
        chk("xori_aluop", {27'b0, ALUOp}, 32'h05);

        // Flush in the second MULWAIT cycle
        Instruction = r_ins(6'b011001, 5'd1, 5'd0);   // multu
        step();
        chk("multu_aluop", {27'b0, ALUOp}, 32'h0d);
        InValid = 1'b0;
        step();
        chk("flush_pre_busy", {31'b0, MulBusy}, 32'd1);
        Flush       = 1'b1;
        InValid     = 1'b1;
        Instruction = i_ins(6'b001100);               // andi must not be taken
        #1;
        chk("flush_inready", {31'b0, InReady}, 32'd0);
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        #1;
        chk("flush_outvalid", {31'b0, OutValid}, 32'd0);
        chk("flush_mulbusy", {31'b0, MulBusy}, 32'd0);
        chk("flush_inready_after", {31'b0, InReady}, 32'd1);
        chk("flush_aluop_hold", {27'b0, ALUOp}, 32'h0d);

        // illegal opcode
        Instruction = {6'b111111, 26'd0};
        InValid     = 1'b1;
        step();
        chk("ill_outvalid", {31'b0, OutValid}, 32'd1);
        chk("ill_aluop", {27'b0, ALUOp}, 32'h00);
        chk("ill_illegal", {31'b0, Illegal}, 32'd1);

        // more decode entries, issued back to back
        tv_ins[0] = {6'b011111, 5'd0, 5'd2, 5'd3, 5'b11000, 6'b100000}; tv_op[0] = 5'b01011; // seh
        tv_ins[1] = {6'b011111, 5'd0, 5'd2, 5'd3, 5'b10000, 6'b100000}; tv_op[1] = 5'b01111; // seb
        tv_ins[2] = r_ins(6'b101011, 5'd1, 5'd0);                        tv_op[2] = 5'b10000; // sltu
        tv_ins[3] = r_ins(6'b001010, 5'd1, 5'd0);                        tv_op[3] = 5'b10101; // movz
        tv_ins[4] = r_ins(6'b000100, 5'd1, 5'd0);                        tv_op[4] = 5'b10001; // sllv
        tv_ins[5] = i_ins(6'b001011);                                    tv_op[5] = 5'b10000; // sltiu
        tv_ins[6] = r_ins(6'b000111, 5'd1, 5'd0);                        tv_op[6] = 5'b10011; // srav
        tv_ins[7] = r_ins(6'b100111, 5'd1, 5'd0);                        tv_op[7] = 5'b00110; // nor
        for (int i = 0; i < 8; i++) begin
            Instruction = tv_ins[i];
            step();
            chk($sformatf("tbl%0d_aluop", i), {27'b0, ALUOp}, {27'b0, tv_op[i]});
            chk($sformatf("tbl%0d_illegal", i), {31'b0, Illegal}, 32'd0);
        end

        // SPECIAL2 mul is multiply-class
        Instruction = {6'b011100, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000010};
        step();
        InValid = 1'b0;
        chk("mul_aluop", {27'b0, ALUOp}, 32'h02);
        chk("mul_ismul", {31'b0, IsMulClass}, 32'd1);
        chk("mul_busy", {31'b0, MulBusy}, 32'd1);
        step();
        step();
        step();
        chk("mul_done_busy", {31'b0, MulBusy}, 32'd0);

`ifdef ALU_CTRL_STATS_EN
        // add, srl, rotrv, rotr, mult, addi, ori, xori, multu, illegal, 8 table, mul
        chk("stats_accept", AcceptCount, 32'd19);
        // 3 cycles waiting on mult + 1 flush cycle with InValid high
        chk("stats_mulstall", MulStallCount, 32'd4);
`endif

        // reset in the middle of MULWAIT
        Instruction = {6'b011100, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000000};  // madd
        InValid     = 1'b1;
        step();
        InValid = 1'b0;
        chk("madd_busy", {31'b0, MulBusy}, 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        #1;
        chk("rst2_mulbusy", {31'b0, MulBusy}, 32'd0);
        chk("rst2_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst2_aluop", {27'b0, ALUOp}, 32'd0);
        chk("rst2_ismul", {31'b0, IsMulClass}, 32'd0);
        chk("rst2_inready", {31'b0, InReady}, 32'd1);
`ifdef ALU_CTRL_STATS_EN
        chk("rst2_accept", AcceptCount, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
